// File: rtl/mux_share_arbiter.sv
// ============================================================================
// Module      : mux_share_arbiter
// Description : Round-robin arbiter time-sharing a 2-to-1 mux between X and Y
//               requesters, with a hold counter that bounds contended grants.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mux_share_arbiter #(
   parameter int WIDTH    = 4,
   parameter int MAX_HOLD = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             req_x,
   input  logic             req_y,
   input  logic [WIDTH-1:0] X,
   input  logic [WIDTH-1:0] Y,
   output logic             gnt_x,
   output logic             gnt_y,
   output logic             s,
   output logic [WIDTH-1:0] M,
   output logic             m_valid
);

   localparam int c_CNT_W = $clog2(MAX_HOLD) + 1;
   localparam logic [c_CNT_W-1:0] c_HOLD_LAST = c_CNT_W'(MAX_HOLD - 1);
   localparam logic [c_CNT_W-1:0] c_CNT_ONE   = c_CNT_W'(1);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_GNT_X = 2'd1,
      ST_GNT_Y = 2'd2
   } state_t;

   state_t             r_state;
   state_t             w_state_nxt;
   logic [c_CNT_W-1:0] r_hold_cnt;
   logic [c_CNT_W-1:0] w_cnt_nxt;
   logic               r_last;      // 0: X was granted last, 1: Y
   logic [WIDTH-1:0]   r_m;
   logic               r_m_valid;
   logic               w_busy;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state    <= ST_IDLE;
         r_hold_cnt <= '0;
         r_last     <= 1'b1;
      end else begin
         r_state    <= w_state_nxt;
         r_hold_cnt <= w_cnt_nxt;
         if (w_state_nxt == ST_GNT_X) begin
            r_last <= 1'b0;
         end else if (w_state_nxt == ST_GNT_Y) begin
            r_last <= 1'b1;
         end
      end
   end

   // The hold counter only advances while the other side is waiting.
   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = '0;
      case (r_state)
         ST_IDLE: begin
            if (req_x && req_y) begin
               w_state_nxt = r_last ? ST_GNT_X : ST_GNT_Y;
            end else if (req_x) begin
               w_state_nxt = ST_GNT_X;
            end else if (req_y) begin
               w_state_nxt = ST_GNT_Y;
            end
         end
         ST_GNT_X: begin
            if (!req_x) begin
               w_state_nxt = req_y ? ST_GNT_Y : ST_IDLE;
            end else if (req_y) begin
               if (r_hold_cnt == c_HOLD_LAST) begin
                  w_state_nxt = ST_GNT_Y;
               end else begin
                  w_cnt_nxt = r_hold_cnt + c_CNT_ONE;
               end
            end
         end
         ST_GNT_Y: begin
            if (!req_y) begin
               w_state_nxt = req_x ? ST_GNT_X : ST_IDLE;
            end else if (req_x) begin
               if (r_hold_cnt == c_HOLD_LAST) begin
                  w_state_nxt = ST_GNT_X;
               end else begin
                  w_cnt_nxt = r_hold_cnt + c_CNT_ONE;
               end
            end
         end
         default: begin
            w_state_nxt = ST_IDLE;
         end
      endcase
   end

   assign gnt_x  = (r_state == ST_GNT_X);
   assign gnt_y  = (r_state == ST_GNT_Y);
   assign s      = (r_state == ST_GNT_Y);
   assign w_busy = gnt_x | gnt_y;

   // M keeps its last word while idle; only granted cycles load it.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_m       <= '0;
         r_m_valid <= 1'b0;
      end else begin
         if (w_busy) begin
            r_m <= s ? Y : X;
         end
         r_m_valid <= w_busy;
      end
   end

   assign M       = r_m;
   assign m_valid = r_m_valid;

endmodule

`default_nettype wire
